arc4_prga_encrypt: RTL and testbench

- Keystream (PRGA) stage of the ARC4 datapath, run after init and KSA have prepared S in the 256x8 S memory.
- Reads a length-prefixed plaintext message from PT memory, XORs each byte with the ARC4 keystream, and writes the length-prefixed ciphertext to CT memory.
- Mutates S (swaps) exactly as ARC4 requires; it is the writer/encrypt counterpart of the decrypt path.
- Uses the team's rdy/en start handshake so the top-level controller can sequence it after KSA.

---
 rtl/arc4_prga_encrypt_if.sv | 35 +++
 rtl/arc4_prga_encrypt.sv | 170 +++++++++++++++++
 tb/tb_arc4_prga_encrypt.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_prga_encrypt_if.sv
// Bus bundle for the ARC4 PRGA/encrypt stage: start handshake plus S, PT and CT memory ports.
// ARC4_PRGA_KS_TAP_EN adds the keystream tap signals ks_valid/ks_byte.
interface arc4_prga_encrypt_if;
   logic       en;
   logic       rdy;
   logic [7:0] s_addr;
   logic [7:0] s_rddata;
   logic [7:0] s_wrdata;
   logic       s_wren;
   logic [7:0] pt_addr;
   logic [7:0] pt_rddata;
   logic [7:0] ct_addr;
   logic [7:0] ct_wrdata;
   logic       ct_wren;
`ifdef ARC4_PRGA_KS_TAP_EN
   logic       ks_valid;
   logic [7:0] ks_byte;
`endif

   modport master (
      input  en, s_rddata, pt_rddata,
`ifdef ARC4_PRGA_KS_TAP_EN
      output ks_valid, ks_byte,
`endif
      output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
   );

   modport slave (
      output en, s_rddata, pt_rddata,
`ifdef ARC4_PRGA_KS_TAP_EN
      input  ks_valid, ks_byte,
`endif
      input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
   );
endinterface

// File: rtl/arc4_prga_encrypt.sv
// ARC4 keystream stage: encrypts a length-prefixed PT message into CT while permuting S.
// Optional keystream tap (ks_valid/ks_byte) is built when ARC4_PRGA_KS_TAP_EN is defined.
module arc4_prga_encrypt #(
   parameter int WRITE_LEN = 1,
   parameter int MAX_LEN   = 255
) (
   input logic                 clk,
   input logic                 rst,
   arc4_prga_encrypt_if.master bus
);
   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] LEN_RD  = 4'd1;
   localparam logic [3:0] LEN_LAT = 4'd2;
   localparam logic [3:0] LEN_WR  = 4'd3;
   localparam logic [3:0] SI_RD   = 4'd4;
   localparam logic [3:0] SI_LAT  = 4'd5;
   localparam logic [3:0] SJ_RD   = 4'd6;
   localparam logic [3:0] SJ_LAT  = 4'd7;
   localparam logic [3:0] SWAP_I  = 4'd8;
   localparam logic [3:0] SWAP_J  = 4'd9;
   localparam logic [3:0] PAD_RD  = 4'd10;
   localparam logic [3:0] PAD_LAT = 4'd11;
   localparam logic [3:0] CT_WR   = 4'd12;
   localparam logic [3:0] DONE    = 4'd13;

   localparam logic [7:0] MAX_L    = 8'(MAX_LEN);
   localparam logic       LEN_WREN = (WRITE_LEN != 0);

   function automatic logic [7:0] clamp_len(input logic [7:0] raw);
      return (raw > MAX_L) ? MAX_L : raw;
   endfunction

   logic [3:0] state;
   logic       rdy;
   logic [7:0] s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata;
   logic       s_wren, ct_wren;
   logic [7:0] i, j, k, len, si, sj;

   assign bus.rdy       = rdy;
   assign bus.s_addr    = s_addr;
   assign bus.s_wrdata  = s_wrdata;
   assign bus.s_wren    = s_wren;
   assign bus.pt_addr   = pt_addr;
   assign bus.ct_addr   = ct_addr;
   assign bus.ct_wrdata = ct_wrdata;
   assign bus.ct_wren   = ct_wren;

`ifdef ARC4_PRGA_KS_TAP_EN
   logic       ks_valid;
   logic [7:0] ks_byte;
   assign bus.ks_valid = ks_valid;
   assign bus.ks_byte  = ks_byte;
`endif

   // Outputs are registered on entry to the state that owns them, so each
   // address is stable for the whole cycle the synchronous RAMs sample it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rdy       <= 1'b1;
         s_addr    <= 8'd0;
         s_wrdata  <= 8'd0;
         s_wren    <= 1'b0;
         pt_addr   <= 8'd0;
         ct_addr   <= 8'd0;
         ct_wrdata <= 8'd0;
         ct_wren   <= 1'b0;
         i         <= 8'd0;
         j         <= 8'd0;
         k         <= 8'd0;
         len       <= 8'd0;
         si        <= 8'd0;
         sj        <= 8'd0;
`ifdef ARC4_PRGA_KS_TAP_EN
         ks_valid  <= 1'b0;
         ks_byte   <= 8'd0;
`endif
      end else begin
         s_wren  <= 1'b0;
         ct_wren <= 1'b0;
`ifdef ARC4_PRGA_KS_TAP_EN
         ks_valid <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.en) begin
                  state   <= LEN_RD;
                  rdy     <= 1'b0;
                  pt_addr <= 8'd0;
                  i       <= 8'd0;
                  j       <= 8'd0;
                  k       <= 8'd1;
               end
            end
            LEN_RD: state <= LEN_LAT;
            LEN_LAT: begin
               len       <= clamp_len(bus.pt_rddata);
               ct_addr   <= 8'd0;
               ct_wrdata <= clamp_len(bus.pt_rddata);
               ct_wren   <= LEN_WREN;
               state     <= LEN_WR;
            end
            LEN_WR: begin
               if (len == 8'd0) begin
                  state <= DONE;
               end else begin
                  i      <= i + 8'd1;
                  s_addr <= i + 8'd1;
                  state  <= SI_RD;
               end
            end
            SI_RD: state <= SI_LAT;
            SI_LAT: begin
               si     <= bus.s_rddata;
               j      <= j + bus.s_rddata;
               s_addr <= j + bus.s_rddata;
               state  <= SJ_RD;
            end
            SJ_RD: state <= SJ_LAT;
            SJ_LAT: begin
               sj       <= bus.s_rddata;
               s_addr   <= i;
               s_wrdata <= bus.s_rddata;
               s_wren   <= 1'b1;
               state    <= SWAP_I;
            end
            SWAP_I: begin
               s_addr   <= j;
               s_wrdata <= si;
               s_wren   <= 1'b1;
               state    <= SWAP_J;
            end
            SWAP_J: begin
               s_addr  <= si + sj;
               pt_addr <= k;
               state   <= PAD_RD;
            end
            PAD_RD: state <= PAD_LAT;
            PAD_LAT: begin
               ct_addr   <= k;
               ct_wrdata <= bus.s_rddata ^ bus.pt_rddata;
               ct_wren   <= 1'b1;
`ifdef ARC4_PRGA_KS_TAP_EN
               ks_valid  <= 1'b1;
               ks_byte   <= bus.s_rddata;
`endif
               state     <= CT_WR;
            end
            CT_WR: begin
               if (k == len) begin
                  state <= DONE;
               end else begin
                  k      <= k + 8'd1;
                  i      <= i + 8'd1;
                  s_addr <= i + 8'd1;
                  state  <= SI_RD;
               end
            end
            DONE: begin
               rdy   <= 1'b1;
               state <= IDLE;
            end
            default: begin
               rdy   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_arc4_prga_encrypt.sv
// Randomised self-checking bench for arc4_prga_encrypt against a plain ARC4 reference model.
module tb_arc4_prga_encrypt;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arc4_prga_encrypt_if bus ();
   arc4_prga_encrypt_if bus2 ();

   arc4_prga_encrypt #(.WRITE_LEN(1), .MAX_LEN(255)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
   arc4_prga_encrypt #(.WRITE_LEN(0), .MAX_LEN(5))   dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

   logic [7:0] s_mem [256];
   logic [7:0] pt_mem[256];
   logic [7:0] ct_mem[256];
   logic [7:0] s_init[256];
   logic       load_req = 1'b0;
   int ct_wr_cnt = 0, ct_wr_cnt2 = 0, s_wr_cnt = 0;
   int snap_ct, snap_ct2, snap_s, snap_ks;
   int nchecks = 0, nerr = 0;

   // Shared synchronous memories; only one DUT is active at a time.
   always @(posedge clk) begin
      bus.s_rddata   <= s_mem[bus.s_addr];
      bus.pt_rddata  <= pt_mem[bus.pt_addr];
      bus2.s_rddata  <= s_mem[bus2.s_addr];
      bus2.pt_rddata <= pt_mem[bus2.pt_addr];
      if (load_req) begin
         for (int a = 0; a < 256; a++) begin
            s_mem[a]  <= s_init[a];
            ct_mem[a] <= 8'hEE;
         end
      end else begin
         if (bus.s_wren) begin
            s_mem[bus.s_addr] <= bus.s_wrdata;
            s_wr_cnt <= s_wr_cnt + 1;
         end
         if (bus2.s_wren) begin
            s_mem[bus2.s_addr] <= bus2.s_wrdata;
            s_wr_cnt <= s_wr_cnt + 1;
         end
         if (bus.ct_wren) begin
            ct_mem[bus.ct_addr] <= bus.ct_wrdata;
            ct_wr_cnt <= ct_wr_cnt + 1;
         end
         if (bus2.ct_wren) begin
            ct_mem[bus2.ct_addr] <= bus2.ct_wrdata;
            ct_wr_cnt2 <= ct_wr_cnt2 + 1;
         end
      end
   end

`ifdef ARC4_PRGA_KS_TAP_EN
   logic [7:0] ks_cap[256];
   int ks_cnt = 0;
   always @(posedge clk) begin
      if (bus.ks_valid) begin
         ks_cap[bus.ct_addr] <= bus.ks_byte;
         ks_cnt <= ks_cnt + 1;
      end
   end
`endif

   // Reference model: textbook ARC4 PRGA over a copy of the initial S.
   logic [7:0] m_s[256], m_ct[256], m_ks[256];
   int m_len;

   task automatic model_run(input int maxl);
      int ii, jj, a, b;
      logic [7:0] t;
      m_s   = s_init;
      m_len = (pt_mem[0] > maxl) ? maxl : int'(pt_mem[0]);
      ii = 0;
      jj = 0;
      for (int n = 1; n <= m_len; n++) begin
         ii = (ii + 1) % 256;
         jj = (jj + m_s[ii]) % 256;
         t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
         a = m_s[ii];
         b = m_s[jj];
         m_ks[n] = m_s[(a + b) % 256];
         m_ct[n] = pt_mem[n] ^ m_ks[n];
      end
   endtask

   task automatic ksa(input logic [23:0] key);
      int jj;
      logic [7:0] t, kb;
      jj = 0;
      for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
      for (int a = 0; a < 256; a++) begin
         case (a % 3)
            0:       kb = key[23:16];
            1:       kb = key[15:8];
            default: kb = key[7:0];
         endcase
         jj = (jj + s_init[a] + kb) % 256;
         t = s_init[a]; s_init[a] = s_init[jj]; s_init[jj] = t;
      end
   endtask

   task automatic identity_s();
      for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
   endtask

   task automatic random_pt(input int len);
      pt_mem[0] = 8'(len);
      for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom);
   endtask

   task automatic load_mem();
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
      snap_ct  = ct_wr_cnt;
      snap_ct2 = ct_wr_cnt2;
      snap_s   = s_wr_cnt;
`ifdef ARC4_PRGA_KS_TAP_EN
      snap_ks  = ks_cnt;
`else
      snap_ks  = 0;
`endif
   endtask

   // Starts one run and counts the cycles rdy stays low (bounded).
   task automatic run_dut(input bit second, input bit hold, input bit jitter, output int low);
      @(negedge clk);
      if (second) bus2.en = 1'b1; else bus.en = 1'b1;
      @(negedge clk);
      if (!hold) begin bus.en = 1'b0; bus2.en = 1'b0; end
      low = 0;
      while ((second ? bus2.rdy : bus.rdy) == 1'b0 && low <= 4000) begin
         low++;
         if (hold) begin
            if (second) bus2.en = 1'b1; else bus.en = 1'b1;
         end else if (jitter) begin
            if (second) bus2.en = 1'($urandom_range(0, 1)); else bus.en = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      bus.en  = 1'b0;
      bus2.en = 1'b0;
   endtask

   task automatic check_run(input string name, input bit second, input bit wl, input int low);
      int bad, d;
      logic [7:0] exp;
      nchecks++;
      if (low !== 4 + 9 * m_len) begin
         nerr++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, low, 4 + 9 * m_len);
      end
      exp = wl ? 8'(m_len) : 8'hEE;
      nchecks++;
      if (ct_mem[0] !== exp) begin
         nerr++; $display("FAIL %s_ct0: got %h expected %h", name, ct_mem[0], exp);
      end
      bad = 0;
      for (int a = 1; a < 256; a++) begin
         exp = (a <= m_len) ? m_ct[a] : 8'hEE;
         if (ct_mem[a] !== exp) bad++;
      end
      nchecks++;
      if (bad != 0) begin
         nerr++; $display("FAIL %s_ct_bytes: got %0d wrong bytes expected 0", name, bad);
      end
      bad = 0;
      for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
      nchecks++;
      if (bad != 0) begin
         nerr++; $display("FAIL %s_s_state: got %0d wrong entries expected 0", name, bad);
      end
      d = second ? (ct_wr_cnt2 - snap_ct2) : (ct_wr_cnt - snap_ct);
      nchecks++;
      if (d != m_len + int'(wl)) begin
         nerr++; $display("FAIL %s_ct_writes: got %0d expected %0d", name, d, m_len + int'(wl));
      end
      d = s_wr_cnt - snap_s;
      nchecks++;
      if (d != 2 * m_len) begin
         nerr++; $display("FAIL %s_s_writes: got %0d expected %0d", name, d, 2 * m_len);
      end
`ifdef ARC4_PRGA_KS_TAP_EN
      if (!second) begin
         nchecks++;
         if (ks_cnt - snap_ks != m_len) begin
            nerr++; $display("FAIL %s_ks_pulses: got %0d expected %0d", name, ks_cnt - snap_ks, m_len);
         end
         bad = 0;
         for (int a = 1; a <= m_len; a++) if (ks_cap[a] !== m_ks[a]) bad++;
         nchecks++;
         if (bad != 0) begin
            nerr++; $display("FAIL %s_ks_bytes: got %0d wrong expected 0", name, bad);
         end
      end
`endif
   endtask

   task automatic encrypt(input string name, input bit second, input bit hold, input bit jitter);
      int low;
      load_mem();
      model_run(second ? 5 : 255);
      run_dut(second, hold, jitter, low);
      check_run(name, second, !second, low);
   endtask

   task automatic test_reset();
      bus.en = 1'b0; bus2.en = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      nchecks++;
      if (bus.rdy !== 1'b1) begin nerr++; $display("FAIL reset_rdy: got %b expected 1", bus.rdy); end
      nchecks++;
      if ({bus.s_wren, bus.ct_wren} !== 2'b00) begin
         nerr++; $display("FAIL reset_wren: got %b expected 00", {bus.s_wren, bus.ct_wren});
      end
      nchecks++;
      if ({bus.s_addr, bus.s_wrdata, bus.pt_addr, bus.ct_addr, bus.ct_wrdata} !== 40'd0) begin
         nerr++; $display("FAIL reset_bus: got %h expected 0",
                          {bus.s_addr, bus.s_wrdata, bus.pt_addr, bus.ct_addr, bus.ct_wrdata});
      end
      rst = 1'b0;
   endtask

   task automatic test_identity();
      identity_s();
      random_pt(1); pt_mem[1] = 8'h00;
      encrypt("ident_len1", 1'b0, 1'b0, 1'b0);
      nchecks++;
      if (ct_mem[1] !== 8'h02 || s_mem[1] !== 8'h01) begin
         nerr++; $display("FAIL ident_len1_const: got ct1=%h s1=%h expected 02 01", ct_mem[1], s_mem[1]);
      end
      random_pt(2); pt_mem[1] = 8'h00; pt_mem[2] = 8'h00;
      encrypt("ident_len2", 1'b0, 1'b0, 1'b0);
      nchecks++;
      if ({ct_mem[1], ct_mem[2], s_mem[2], s_mem[3]} !== 32'h02050302) begin
         nerr++; $display("FAIL ident_len2_const: got %h expected 02050302",
                          {ct_mem[1], ct_mem[2], s_mem[2], s_mem[3]});
      end
   endtask

   task automatic test_zero_len();
      ksa(24'($urandom));
      random_pt(0);
      encrypt("zero_len", 1'b0, 1'b0, 1'b0);
      random_pt(0);
      encrypt("zero_len_nowrite", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_clamp_nowrite();
      ksa(24'($urandom));
      random_pt($urandom_range(6, 255));
      encrypt("clamp_nowrite", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_decrypt();
      logic [7:0] c1, c2;
      ksa(24'h000318);
      random_pt(2); pt_mem[1] = 8'h68; pt_mem[2] = 8'h69;
      encrypt("encrypt_hi", 1'b0, 1'b0, 1'b0);
      c1 = ct_mem[1]; c2 = ct_mem[2];
      ksa(24'h000318);
      random_pt(2); pt_mem[1] = c1; pt_mem[2] = c2;
      encrypt("decrypt_hi", 1'b0, 1'b0, 1'b0);
      nchecks++;
      if (ct_mem[1] !== 8'h68 || ct_mem[2] !== 8'h69) begin
         nerr++; $display("FAIL decrypt_roundtrip: got %h%h expected 6869", ct_mem[1], ct_mem[2]);
      end
   endtask

   task automatic test_en_robust();
      ksa(24'($urandom));
      random_pt(6);
      encrypt("en_held", 1'b0, 1'b1, 1'b0);
      random_pt(7);
      encrypt("en_jitter", 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      ksa(24'($urandom));
      random_pt(10);
      load_mem();
      model_run(255);
      @(negedge clk); bus.en = 1'b1;
      @(negedge clk); bus.en = 1'b0;
      repeat (25) @(negedge clk);
      nchecks++;
      if (bus.s_wren !== 1'b1) begin nerr++; $display("FAIL midrst_pre_swap: got %b expected 1", bus.s_wren); end
      #1 rst = 1'b1;
      #1;
      nchecks++;
      if ({bus.rdy, bus.s_wren, bus.ct_wren} !== 3'b100) begin
         nerr++; $display("FAIL midrst_async: got %b expected 100", {bus.rdy, bus.s_wren, bus.ct_wren});
      end
      nchecks++;
      if ({ct_mem[1], ct_mem[2], ct_mem[3]} !== {m_ct[1], m_ct[2], 8'hEE}) begin
         nerr++; $display("FAIL midrst_partial_ct: got %h expected %h",
                          {ct_mem[1], ct_mem[2], ct_mem[3]}, {m_ct[1], m_ct[2], 8'hEE});
      end
      @(negedge clk); rst = 1'b0;
      encrypt("after_midrst", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_long();
      ksa(24'($urandom));
      random_pt(255);
      encrypt("len255", 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) begin
         ksa(24'($urandom));
         random_pt($urandom_range(1, 255));
         encrypt("random_len", 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_zero_len();
      test_clamp_nowrite();
      test_decrypt();
      test_en_robust();
      test_reset_mid();
      test_long();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule
